// File: rtl/spi_master_tx_if.sv
// Byte stream and SPI pin bundle for spi_master_tx.
// slave: the SPI initiator itself; master: the fabric/bench side.
interface spi_master_tx_if;
  logic       iTxValid;
  logic [7:0] iTx;
  logic       iTxLast;
  logic       oTxReady;
  logic [7:0] oRx;
  logic       oRxReady;
  logic       oSPIClk;
  logic       oSPIMOSI;
  logic       oSPICS;
  logic       iSPIMISO;

  modport slave (
    input  iTxValid, iTx, iTxLast, iSPIMISO,
    output oTxReady, oRx, oRxReady, oSPIClk, oSPIMOSI, oSPICS
  );

  modport master (
    output iTxValid, iTx, iTxLast, iSPIMISO,
    input  oTxReady, oRx, oRxReady, oSPIClk, oSPIMOSI, oSPICS
  );
endinterface

// File: rtl/spi_master_tx.sv
// Mode-0 SPI initiator (CPOL=0, CPHA=0), MSB first, with CS framing.
// SCLK, MOSI and CS are registered; SCLK is derived from iClk by a counter.
module spi_master_tx #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 3
) (
  input  logic             iClk,
  input  logic             iRst,
  spi_master_tx_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_NEXT, S_HOLD, S_GAP
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_txsh, r_rxsh, r_rx;
  logic        r_last, r_rx_ready, r_sclk, r_mosi, r_cs;

  logic [31:0] w_cnt32;
  logic        w_setup_done, w_half_done, w_hold_done, w_gap_done;
  logic        w_tx_ready, w_accept;

  assign w_cnt32      = {16'd0, r_cnt};
  assign w_setup_done = (w_cnt32 + 32'd1 == CS_SETUP);
  assign w_half_done  = (w_cnt32 + 32'd1 == CLK_DIV);
  // DONE already supplies one hold cycle, so HOLD itself lasts CS_HOLD-1 cycles
  assign w_hold_done  = (w_cnt32 + 32'd2 >= CS_HOLD);
  assign w_gap_done   = (w_cnt32 + 32'd1 == CS_GAP);

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      S_SETUP: if (w_setup_done) w_next = S_SHIFT;
      S_SHIFT: if (w_half_done && r_sclk && (r_bit == 3'd0)) w_next = S_DONE;
      S_DONE:  begin
        if (!r_last)          w_next = S_NEXT;
        else if (CS_HOLD > 1) w_next = S_HOLD;
        else                  w_next = S_GAP;
      end
      S_NEXT:  if (w_accept) w_next = S_SHIFT;
      S_HOLD:  if (w_hold_done) w_next = S_GAP;
      S_GAP:   if (w_gap_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs; ready is masked while reset is asserted
  always_comb begin
    w_tx_ready = 1'b0;
    if (!iRst && (r_state == S_IDLE || r_state == S_NEXT)) w_tx_ready = 1'b1;
    w_accept = w_tx_ready & bus.iTxValid;
  end

  // Datapath: timing counter, shift registers and registered SPI pins
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_txsh     <= '0;
      r_rxsh     <= '0;
      r_rx       <= '0;
      r_last     <= 1'b0;
      r_rx_ready <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs       <= 1'b1;
    end else begin
      r_rx_ready <= 1'b0;

      if (w_next != r_state || r_state == S_IDLE || r_state == S_NEXT ||
          (r_state == S_SHIFT && w_half_done))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;

      if (w_accept) begin
        r_cs   <= 1'b0;
        r_mosi <= bus.iTx[7];
        r_txsh <= bus.iTx;
        r_last <= bus.iTxLast;
        r_bit  <= 3'd7;
      end

      if (w_next == S_GAP) r_cs <= 1'b1;

      if (r_state == S_SHIFT && w_half_done) begin
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rxsh <= {r_rxsh[6:0], bus.iSPIMISO};
        end else begin
          r_sclk <= 1'b0;
          if (r_bit == 3'd0) begin
            r_rx       <= r_rxsh;
            r_rx_ready <= 1'b1;
          end else begin
            r_bit  <= r_bit - 3'd1;
            r_mosi <= r_txsh[6];
            r_txsh <= {r_txsh[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign bus.oTxReady = w_tx_ready;
  assign bus.oRx      = r_rx;
  assign bus.oRxReady = r_rx_ready;
  assign bus.oSPIClk  = r_sclk;
  assign bus.oSPIMOSI = r_mosi;
  assign bus.oSPICS   = r_cs;

endmodule
